doppler_map_writer: RTL

Receives the Doppler FFT output stream produced by the ping-pong corner-turn controller and writes the range-Doppler magnitude map into a double-buffered map BRAM. Each 256-sample Doppler frame is one range bin, and 128 frames form one map bank. The block computes an |I|+|Q| magnitude per sample and checks the frame framing against `tlast`. It also manages bank ownership with the downstream detector (CFAR) through done/release handshakes.

---
 rtl/doppler_map_writer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/doppler_map_writer.sv
`default_nettype none
// ============================================================================
// doppler_map_writer : |I|+|Q| range-Doppler map writer with double-buffered
// bank handshake. Optional macro DOPPLER_FFTSHIFT_EN centres zero velocity.
// Revision: 1.0
// ============================================================================
module doppler_map_writer #(
  parameter int N_DOPPLER = 256,
  parameter int N_RANGE   = 128,
  parameter int ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              map_en,
  output logic              map_we,
  output logic              map_bank,
  output logic [ADDR_W-1:0] map_addr,
  output logic [16:0]       map_din,
  output logic              frame_done,
  output logic              done_bank,
  input  logic              rd_release,
  input  logic              rd_release_bank,
  output logic              tlast_err,
  output logic              drop_err,
  input  logic              err_clr
);

  localparam int DOP_W = $clog2(N_DOPPLER);
  localparam int RNG_W = $clog2(N_RANGE);
  localparam logic [DOP_W-1:0] DOP_LAST = DOP_W'(N_DOPPLER - 1);
  localparam logic [RNG_W-1:0] RNG_LAST = RNG_W'(N_RANGE - 1);
`ifdef DOPPLER_FFTSHIFT_EN
  localparam logic [DOP_W-1:0] DOP_HALF = DOP_W'(N_DOPPLER / 2);
`endif

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        bank_full_q, bank_full_d;
  logic [DOP_W-1:0]  dop_idx_q, dop_idx_d;
  logic [RNG_W-1:0]  rng_idx_q, rng_idx_d;
  logic              tlast_err_q, tlast_err_d;
  logic              drop_err_q, drop_err_d;
  logic              p1_valid_q, p1_valid_d;
  logic              p1_last_q, p1_last_d;
  logic              p1_bank_q, p1_bank_d;
  logic [ADDR_W-1:0] p1_addr_q, p1_addr_d;
  logic [15:0]       p1_abs_i_q, p1_abs_i_d;
  logic [15:0]       p1_abs_q_q, p1_abs_q_d;
  logic              wr_q, wr_d;
  logic              done_q, done_d;
  logic              done_bank_q, done_bank_d;
  logic              bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [16:0]       din_q, din_d;

  logic              accept, at_dop_end, frame_end, bank_end;
  logic [1:0]        rel_mask, set_mask;
  logic [DOP_W-1:0]  dop_wr;

  // Two's-complement magnitude; 0x8000 maps to 32768, which still fits 16 bits.
  function automatic logic [15:0] mag16(input logic [15:0] x);
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_INIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RUN;
      ST_RUN:  if (bank_end && bank_full_d[wr_bank_d]) state_d = ST_HOLD;
      ST_HOLD: if (!bank_full_d[wr_bank_q]) state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    s_tready = (state_q == ST_RUN);
  end

  always_comb begin
    accept     = s_tvalid & s_tready;
    at_dop_end = (dop_idx_q == DOP_LAST);
    frame_end  = accept & (at_dop_end | s_tlast);
    bank_end   = frame_end & (rng_idx_q == RNG_LAST);

    // Release is applied before completion so a release aimed at the bank
    // still being filled cannot cancel its own completion.
    rel_mask    = rd_release ? (rd_release_bank ? 2'b10 : 2'b01) : 2'b00;
    set_mask    = bank_end ? (wr_bank_q ? 2'b10 : 2'b01) : 2'b00;
    bank_full_d = (bank_full_q & ~rel_mask) | set_mask;
    wr_bank_d   = wr_bank_q ^ bank_end;

    dop_idx_d = dop_idx_q;
    rng_idx_d = rng_idx_q;
    if (frame_end) begin
      dop_idx_d = '0;
      rng_idx_d = rng_idx_q + 1'b1;
    end else if (accept) begin
      dop_idx_d = dop_idx_q + 1'b1;
    end

    tlast_err_d = (accept & (s_tlast ^ at_dop_end)) | (tlast_err_q & ~err_clr);
    drop_err_d  = (s_tvalid & ~s_tready) | (drop_err_q & ~err_clr);

`ifdef DOPPLER_FFTSHIFT_EN
    dop_wr = dop_idx_q ^ DOP_HALF;
`else
    dop_wr = dop_idx_q;
`endif

    p1_valid_d = accept;
    p1_last_d  = bank_end;
    p1_bank_d  = accept ? wr_bank_q : p1_bank_q;
    p1_addr_d  = accept ? ADDR_W'({rng_idx_q, dop_wr}) : p1_addr_q;
    p1_abs_i_d = accept ? mag16(s_tdata[31:16]) : p1_abs_i_q;
    p1_abs_q_d = accept ? mag16(s_tdata[15:0]) : p1_abs_q_q;

    wr_d        = p1_valid_q;
    done_d      = p1_valid_q & p1_last_q;
    bank_d      = p1_valid_q ? p1_bank_q : bank_q;
    addr_d      = p1_valid_q ? p1_addr_q : addr_q;
    din_d       = p1_valid_q ? ({1'b0, p1_abs_i_q} + {1'b0, p1_abs_q_q}) : din_q;
    done_bank_d = done_d ? p1_bank_q : done_bank_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      dop_idx_q   <= '0;
      rng_idx_q   <= '0;
      tlast_err_q <= 1'b0;
      drop_err_q  <= 1'b0;
      p1_valid_q  <= 1'b0;
      p1_last_q   <= 1'b0;
      p1_bank_q   <= 1'b0;
      p1_addr_q   <= '0;
      p1_abs_i_q  <= '0;
      p1_abs_q_q  <= '0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      done_bank_q <= 1'b0;
      bank_q      <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      bank_full_q <= bank_full_d;
      dop_idx_q   <= dop_idx_d;
      rng_idx_q   <= rng_idx_d;
      tlast_err_q <= tlast_err_d;
      drop_err_q  <= drop_err_d;
      p1_valid_q  <= p1_valid_d;
      p1_last_q   <= p1_last_d;
      p1_bank_q   <= p1_bank_d;
      p1_addr_q   <= p1_addr_d;
      p1_abs_i_q  <= p1_abs_i_d;
      p1_abs_q_q  <= p1_abs_q_d;
      wr_q        <= wr_d;
      done_q      <= done_d;
      done_bank_q <= done_bank_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
    end
  end

  assign map_en     = wr_q;
  assign map_we     = wr_q;
  assign map_bank   = bank_q;
  assign map_addr   = addr_q;
  assign map_din    = din_q;
  assign frame_done = done_q;
  assign done_bank  = done_bank_q;
  assign tlast_err  = tlast_err_q;
  assign drop_err   = drop_err_q;

endmodule
`default_nettype wire
